// File: rtl/axis_output_packer_if.sv
// axis_output_packer_if: AXI4-Stream bundle for the convolution engine output path.
//   tvalid  master -> slave  beat valid
//   tready  slave -> master  sink ready
//   tdata   master -> slave  beat data, DATA_WIDTH bits
//   tkeep   master -> slave  byte enables, DATA_WIDTH/8 bits
//   tlast   master -> slave  final beat of a layer
interface axis_output_packer_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_output_packer.sv
// axis_output_packer: absorbs the engine's non-stalling output stream into an elastic FIFO and
// presents it as an AXI4-Stream master, marking the final beat of each run with tlast.
//   ap_clk, ap_rst_n    clock, asynchronous active-low reset
//   start               pulse: arm a run, latch cfg_out_beats, clear FIFO and status
//   cfg_out_beats       beats expected in this run (0 completes immediately)
//   data_in(_valid)     engine output word and strobe (no backpressure)
//   m_axis_output       AXI4-Stream master (tvalid/tready/tdata/tkeep/tlast)
//   busy                run armed, final beat not yet accepted
//   done                one-cycle pulse after the final handshake
//   overflow            sticky: an input word was dropped
//   fifo_level          registered FIFO occupancy
module axis_output_packer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter int unsigned LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  start,
    input  logic [31:0]           cfg_out_beats,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    axis_output_packer_if.master  m_axis_output,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [LVL_WIDTH-1:0]  fifo_level
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_WIDTH-1:0]  count_q, count_d;
    logic [31:0]           remaining_q, remaining_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] ram_rdata_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic                  byp_sel_q;

    logic run, fifo_empty, fifo_full, tvalid, push, pop;

    always_comb begin
        run        = (state_q == StRun);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == LVL_WIDTH'(FIFO_DEPTH));
        tvalid     = run & ~fifo_empty;
        pop        = tvalid & m_axis_output.tready;
        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push       = run & data_in_valid & ~start & (~fifo_full | pop);
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        if (start) begin
            // Restart discards anything queued, including words from an aborted run.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            remaining_d = cfg_out_beats;
            if (cfg_out_beats == 32'd0) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end else begin
                state_d = StRun;
            end
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + LVL_WIDTH'(push) - LVL_WIDTH'(pop);
            if (data_in_valid && !push) overflow_d = 1'b1;
            if (pop) begin
                remaining_d = remaining_q - 32'd1;
                if (remaining_q == 32'd1) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            byp_sel_q   <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            // The RAM returns old data when the next head is written this same edge.
            byp_sel_q   <= push && (wr_ptr_q == rd_ptr_d);
            byp_data_q  <= data_in;
        end
    end

    // Synchronous-read RAM addressed by the next read pointer, so the registered
    // output always holds the head of the FIFO (first-word-fall-through).
    always_ff @(posedge ap_clk) begin
        if (push) mem[wr_ptr_q] <= data_in;
        ram_rdata_q <= mem[rd_ptr_d];
    end

    assign m_axis_output.tvalid = tvalid;
    assign m_axis_output.tdata  = tvalid ? (byp_sel_q ? byp_data_q : ram_rdata_q) : '0;
    assign m_axis_output.tkeep  = '1;
    assign m_axis_output.tlast  = tvalid & (remaining_q == 32'd1);
    assign busy                 = run;
    assign done                 = done_q;
    assign overflow             = overflow_q;
    assign fifo_level           = count_q;
endmodule

// File: tb/tb_axis_output_packer.sv
// tb_axis_output_packer: directed bench for axis_output_packer. Inputs change on the falling
// edge, outputs are sampled 1 time unit later; handshakes complete on the following rising edge.
module tb_axis_output_packer;
    localparam int unsigned DW  = 64;
    localparam int unsigned LVW = 10;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n;
    logic          start;
    logic [31:0]   cfg_out_beats;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          busy, done, overflow;
    logic [LVW-1:0] fifo_level;

    int n_total = 0;
    int n_bad   = 0;

    axis_output_packer_if #(.DATA_WIDTH(DW)) axis_if ();

    axis_output_packer #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(512),
        .LVL_WIDTH (LVW)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .start        (start),
        .cfg_out_beats(cfg_out_beats),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .m_axis_output(axis_if),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] word(input logic [63:0] base, input int idx);
        return base + 64'h11 * 64'(idx + 1);
    endfunction

    // Pulse start; on return sits 1 unit after the following falling edge.
    task automatic arm(input int cfg);
        @(negedge ap_clk);
        start         = 1'b1;
        cfg_out_beats = 32'(cfg);
        @(negedge ap_clk);
        start = 1'b0;
        #1;
        check("arm_overflow", 64'(overflow), 64'd0);
        check("arm_level", 64'(fifo_level), 64'd0);
        check("arm_busy", 64'(busy), 64'(cfg != 0));
        check("arm_tvalid", 64'(axis_if.tvalid), 64'd0);
        check("arm_done", 64'(done), 64'(cfg == 0));
    endtask

    // Pushes n_push words (one every push_per cycles), tready high one cycle in rdy_per,
    // checks every valid beat against the model until stop_at beats have been accepted.
    task automatic stream(input int n_cfg, input int n_push, input int push_per,
                          input int rdy_per, input logic [63:0] base, input int stop_at);
        int got = 0, pushed = 0, dones = 0, cyc = 0, lvl_max = 0;
        bit fin = 0;
        while (!fin && cyc < 20000) begin
            data_in_valid = (pushed < n_push) && (cyc % push_per == 0);
            data_in       = data_in_valid ? word(base, pushed) : '0;
            if (data_in_valid) pushed++;
            axis_if.tready = (cyc % rdy_per == 0);
            #1;
            if (done) dones++;
            if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
            if (axis_if.tvalid) begin
                check("tdata", axis_if.tdata, word(base, got));
                check("tlast", 64'(axis_if.tlast), 64'(got == n_cfg - 1));
                if (axis_if.tready) got++;
            end
            if (got == stop_at) fin = 1;
            cyc++;
            @(negedge ap_clk);
        end
        data_in_valid  = 1'b0;
        data_in        = '0;
        axis_if.tready = 1'b0;
        if (!fin) check("beat_timeout", 64'(got), 64'(stop_at));
        if (stop_at == n_cfg) begin
            #1;
            check("done_early", 64'(dones), 64'd0);
            check("done_pulse", 64'(done), 64'd1);
            check("busy_fall", 64'(busy), 64'd0);
            check("tvalid_after", 64'(axis_if.tvalid), 64'd0);
            check("lvl_peak", 64'(lvl_max <= 512), 64'd1);
            @(negedge ap_clk);
            #1;
            check("done_once", 64'(done), 64'd0);
        end
    endtask

    initial begin
        ap_rst_n       = 1'b0;
        start          = 1'b0;
        cfg_out_beats  = '0;
        data_in        = '0;
        data_in_valid  = 1'b0;
        axis_if.tready = 1'b0;
        #1;
        check("rst_tvalid", 64'(axis_if.tvalid), 64'd0);
        check("rst_tdata", axis_if.tdata, 64'd0);
        check("rst_tlast", 64'(axis_if.tlast), 64'd0);
        check("rst_tkeep", 64'(axis_if.tkeep), 64'hFF);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Four back-to-back words 0x11..0x44, sink always ready.
        arm(4);
        stream(4, 4, 1, 1, 64'd0, 4);
        check("t1_overflow", 64'(overflow), 64'd0);

        // 1000 beats, sink ready one cycle in three, producer paced to match.
        arm(1000);
        stream(1000, 1000, 3, 3, 64'hA000_0000_0000_0000, 1000);
        check("t2_overflow", 64'(overflow), 64'd0);

        // Fill to capacity with the sink stalled; the 513th word is dropped.
        arm(512);
        for (int i = 0; i < 513; i++) begin
            data_in_valid = 1'b1;
            data_in       = word(64'hB000_0000_0000_0000, i);
            @(negedge ap_clk);
        end
        data_in_valid = 1'b0;
        #1;
        check("t3_level_full", 64'(fifo_level), 64'd512);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_head", axis_if.tdata, word(64'hB000_0000_0000_0000, 0));
        stream(512, 0, 1, 1, 64'hB000_0000_0000_0000, 512);
        check("t3_overflow_sticky", 64'(overflow), 64'd1);

        // Zero-beat run: done next cycle, never busy or valid; also clears overflow.
        arm(0);
        @(negedge ap_clk);
        #1;
        check("t4_done_low", 64'(done), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_tvalid", 64'(axis_if.tvalid), 64'd0);

        // Word arriving while idle is dropped.
        @(negedge ap_clk);
        data_in_valid = 1'b1;
        data_in       = 64'hDEAD;
        @(negedge ap_clk);
        data_in_valid = 1'b0;
        #1;
        check("t5_overflow", 64'(overflow), 64'd1);
        check("t5_tvalid", 64'(axis_if.tvalid), 64'd0);
        check("t5_level", 64'(fifo_level), 64'd0);
        arm(2);
        stream(2, 2, 1, 1, 64'hC000_0000_0000_0000, 2);

        // Reset in the middle of an 8-beat run, then a fresh 2-beat run.
        arm(8);
        stream(8, 8, 1, 1, 64'hD000_0000_0000_0000, 3);
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("t6_tvalid", 64'(axis_if.tvalid), 64'd0);
        check("t6_tdata", axis_if.tdata, 64'd0);
        check("t6_tlast", 64'(axis_if.tlast), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_overflow", 64'(overflow), 64'd0);
        check("t6_level", 64'(fifo_level), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        #1;
        check("t6_idle_tvalid", 64'(axis_if.tvalid), 64'd0);
        arm(2);
        stream(2, 2, 1, 1, 64'hE000_0000_0000_0000, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
